// File: rtl/fpu_decode_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared opcode map, instruction field positions, halt word,
//                FSM state encoding and the multi-cycle opcode set for the
//                FPU decode/issue block.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

   // Opcode map (instr[4:0])
   localparam logic [4:0] OP_FADD      = 5'd0;
   localparam logic [4:0] OP_FSUB      = 5'd1;
   localparam logic [4:0] OP_FMUL      = 5'd2;
   localparam logic [4:0] OP_FDIV      = 5'd3;
   localparam logic [4:0] OP_FSQRT     = 5'd4;
   localparam logic [4:0] OP_FMIN      = 5'd5;
   localparam logic [4:0] OP_FMAX      = 5'd6;
   localparam logic [4:0] OP_FCVT_W_S  = 5'd7;
   localparam logic [4:0] OP_FCVT_WU_S = 5'd8;
   localparam logic [4:0] OP_FMV_X_W   = 5'd9;
   localparam logic [4:0] OP_FEQ       = 5'd10;
   localparam logic [4:0] OP_FLT       = 5'd11;
   localparam logic [4:0] OP_FMADD     = 5'd12;
   localparam logic [4:0] OP_FMSUBB    = 5'd13;
   localparam logic [4:0] OP_FLE       = 5'd14;
   localparam logic [4:0] OP_FCLASS    = 5'd15;
   localparam logic [4:0] OP_FNMSUBB   = 5'd16;
   localparam logic [4:0] OP_FNMADD    = 5'd17;
   localparam logic [4:0] OP_FCVT_S_W  = 5'd18;
   localparam logic [4:0] OP_FCVT_S_WU = 5'd19;
   localparam logic [4:0] OP_FMV_W_X   = 5'd20;
   localparam logic [4:0] OP_FSGNJ     = 5'd21;
   localparam logic [4:0] OP_FSGNJN    = 5'd22;
   localparam logic [4:0] OP_SIGN      = 5'd23;

   localparam int NUM_OPS = 24;

   // Instruction field bit positions
   localparam int OPC_LSB = 0;
   localparam int OPC_W   = 5;
   localparam int RD_LSB  = 5;
   localparam int RS1_LSB = 10;
   localparam int RS2_LSB = 15;
   localparam int RS3_LSB = 20;
   localparam int REG_W   = 5;
   localparam int RM_LSB  = 25;
   localparam int RM_W    = 3;

   localparam logic [31:0] HALT_INSTR = 32'h0000_0010;

   // Multi-cycle set: fdiv, fsqrt, fmadd, fmsubb, fnmsubb, fnmadd
   localparam logic [NUM_OPS-1:0] MULTI_MASK =
      (24'd1 << OP_FDIV)    | (24'd1 << OP_FSQRT)  |
      (24'd1 << OP_FMADD)   | (24'd1 << OP_FMSUBB) |
      (24'd1 << OP_FNMSUBB) | (24'd1 << OP_FNMADD);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic [RM_W-1:0]  rm;
      logic [REG_W-1:0] rs3;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rd;
   } fields_t;

   // Latencies below 2 cannot be sequenced by EXEC + WAIT + DONE
   function automatic int clamp_lat(input int lat);
      return (lat < 2) ? 2 : lat;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_decode_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_decode_issue_if
//  Description : Instruction input and decoded/handshake outputs of the FPU
//                decode/issue block. Optional macro FPU_DECODE_PERF_CNT_EN
//                adds the performance counter signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpu_decode_issue_if;
   import fpu_pkg::*;

   logic [31:0]        instr_in;
   logic [NUM_OPS-1:0] op_onehot;
   logic [REG_W-1:0]   rd;
   logic [REG_W-1:0]   rs1;
   logic [REG_W-1:0]   rs2;
   logic [REG_W-1:0]   rs3;
   logic [RM_W-1:0]    rm;
   logic               issue_valid;
   logic               multi_cycle;
   logic               busy;
   logic               activation_signal;
   logic               illegal_op;
   logic               halt;
   logic               overrun;
`ifdef FPU_DECODE_PERF_CNT_EN
   logic [31:0]        perf_issued;
   logic [31:0]        perf_busy_cycles;
`endif

   modport master (
      output instr_in,
      input  op_onehot, rd, rs1, rs2, rs3, rm, issue_valid, multi_cycle,
             busy, activation_signal, illegal_op, halt, overrun
`ifdef FPU_DECODE_PERF_CNT_EN
      , input perf_issued, perf_busy_cycles
`endif
   );

   modport slave (
      input  instr_in,
      output op_onehot, rd, rs1, rs2, rs3, rm, issue_valid, multi_cycle,
             busy, activation_signal, illegal_op, halt, overrun
`ifdef FPU_DECODE_PERF_CNT_EN
      , output perf_issued, perf_busy_cycles
`endif
   );

endinterface
`default_nettype wire

// File: rtl/fpu_decode_issue_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_opcode_onehot
//  Description : Combinational 5-bit opcode to 24-bit one-hot decoder with a
//                multi-cycle flag. Opcodes 24..31 decode to all zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_opcode_onehot
   import fpu_pkg::*;
(
   input  logic [OPC_W-1:0]   opcode_i,
   output logic [NUM_OPS-1:0] onehot_o,
   output logic               is_multi_o
);

   // One bit per legal opcode; out-of-range opcodes leave the vector empty
   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < NUM_OPS; i++) begin
         onehot_o[i] = (opcode_i == OPC_W'(i));
      end
   end

   assign is_multi_o = |(onehot_o & MULTI_MASK);

endmodule
`default_nettype wire

// File: rtl/fpu_decode_issue.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_decode_issue
//  Description : Decodes instructions from the FPU fetch FSM, issues them and
//                sequences multi-cycle ops with a latency counter, returning
//                multi_cycle and the activation_signal completion pulse.
//                A multi-cycle op's done pulse lands LAT cycles after its
//                issue cycle. Optional macro FPU_DECODE_PERF_CNT_EN adds
//                issue and busy-cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_decode_issue
   import fpu_pkg::*;
#(
   parameter int DIV_LAT  = 12,
   parameter int SQRT_LAT = 14,
   parameter int FMA_LAT  = 3
) (
   input  logic              clk,
   input  logic              rst,
   fpu_decode_issue_if.slave bus
);

   localparam int DIV_L  = clamp_lat(DIV_LAT);
   localparam int SQRT_L = clamp_lat(SQRT_LAT);
   localparam int FMA_L  = clamp_lat(FMA_LAT);
   localparam int MAX_DS = (DIV_L > SQRT_L) ? DIV_L : SQRT_L;
   localparam int MAX_L  = (MAX_DS > FMA_L) ? MAX_DS : FMA_L;
   localparam int CNT_W  = $clog2(MAX_L);

   // EXEC loads LAT-2 so WAIT spans LAT-1 cycles before DONE
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_L - 2);
   localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_L - 2);
   localparam logic [CNT_W-1:0] FMA_LOAD  = CNT_W'(FMA_L - 2);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_OPS-1:0] op_onehot_q, op_onehot_d;
   fields_t            fields_q, fields_d;
   logic               multi_q, multi_d;
   logic               halt_q, halt_d;
   logic               illegal_q, illegal_d;
   logic               overrun_q, overrun_d;

   logic [OPC_W-1:0]   opcode;
   logic [NUM_OPS-1:0] dec_onehot;
   logic               dec_multi;
   logic               dec_legal;
   logic               instr_nz;
   logic               is_halt;
   logic               idle;
   fields_t            fields_in;
   logic [CNT_W-1:0]   lat_load;

   assign opcode    = bus.instr_in[OPC_LSB +: OPC_W];
   assign instr_nz  = |bus.instr_in;
   assign is_halt   = (bus.instr_in == HALT_INSTR);
   assign idle      = (state_q == ST_IDLE);
   assign dec_legal = |dec_onehot;

   assign fields_in.rd  = bus.instr_in[RD_LSB  +: REG_W];
   assign fields_in.rs1 = bus.instr_in[RS1_LSB +: REG_W];
   assign fields_in.rs2 = bus.instr_in[RS2_LSB +: REG_W];
   assign fields_in.rs3 = bus.instr_in[RS3_LSB +: REG_W];
   assign fields_in.rm  = bus.instr_in[RM_LSB  +: RM_W];

   fpu_opcode_onehot u_opcode_onehot (
      .opcode_i   (opcode),
      .onehot_o   (dec_onehot),
      .is_multi_o (dec_multi)
   );

   // Pick the counter preload for the op currently in EXEC
   always_comb begin
      lat_load = FMA_LOAD;
      if (op_onehot_q[OP_FDIV]) begin
         lat_load = DIV_LOAD;
      end else if (op_onehot_q[OP_FSQRT]) begin
         lat_load = SQRT_LOAD;
      end
   end

   // Next-state, field latching and halt/illegal/overrun detection
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_onehot_d = op_onehot_q;
      fields_d    = fields_q;
      multi_d     = multi_q;
      halt_d      = 1'b0;
      illegal_d   = 1'b0;
      overrun_d   = overrun_q | (~idle & instr_nz);
      case (state_q)
         ST_IDLE: begin
            op_onehot_d = '0;
            if (is_halt) begin
               // Halt word shares opcode 16; it must never issue
               halt_d = 1'b1;
            end else if (instr_nz && !dec_legal) begin
               illegal_d = 1'b1;
            end else if (instr_nz) begin
               state_d     = ST_EXEC;
               op_onehot_d = dec_onehot;
               fields_d    = fields_in;
               multi_d     = dec_multi;
            end
         end
         ST_EXEC: begin
            if (multi_q) begin
               state_d = ST_WAIT;
               cnt_d   = lat_load;
            end else begin
               state_d     = ST_IDLE;
               op_onehot_d = '0;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d     = ST_IDLE;
            op_onehot_d = '0;
         end
         default: begin
            state_d     = ST_IDLE;
            op_onehot_d = '0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any op in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_onehot_q <= '0;
         fields_q    <= '0;
         multi_q     <= 1'b0;
         halt_q      <= 1'b0;
         illegal_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_onehot_q <= op_onehot_d;
         fields_q    <= fields_d;
         multi_q     <= multi_d;
         halt_q      <= halt_d;
         illegal_q   <= illegal_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.op_onehot         = op_onehot_q;
   assign bus.rd                = fields_q.rd;
   assign bus.rs1               = fields_q.rs1;
   assign bus.rs2               = fields_q.rs2;
   assign bus.rs3               = fields_q.rs3;
   assign bus.rm                = fields_q.rm;
   assign bus.issue_valid       = (state_q == ST_EXEC);
   assign bus.busy              = ~idle;
   assign bus.multi_cycle       = ~idle & multi_q;
   assign bus.activation_signal = ((state_q == ST_EXEC) & ~multi_q) |
                                  (state_q == ST_DONE) | illegal_q;
   assign bus.illegal_op        = illegal_q;
   assign bus.halt              = halt_q;
   assign bus.overrun           = overrun_q;

`ifdef FPU_DECODE_PERF_CNT_EN
   logic [31:0] perf_issued_q;
   logic [31:0] perf_busy_q;

   // Free-running wrap-around counters of issues and busy cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued_q <= '0;
         perf_busy_q   <= '0;
      end else begin
         if (state_q == ST_EXEC) perf_issued_q <= perf_issued_q + 32'd1;
         if (!idle)              perf_busy_q   <= perf_busy_q + 32'd1;
      end
   end

   assign bus.perf_issued      = perf_issued_q;
   assign bus.perf_busy_cycles = perf_busy_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_decode_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_decode_issue
//  Description : Directed self-checking bench for fpu_decode_issue with a
//                cycle model and an issue scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_decode_issue;

   localparam int          DIV_LAT  = 12;
   localparam int          SQRT_LAT = 14;
   localparam int          FMA_LAT  = 3;
   localparam logic [31:0] HALT_W   = 32'h0000_0010;

   typedef struct {
      logic [23:0] onehot;
      logic [22:0] fields;
      logic        multi;
      int          lat;
   } exp_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   t_issue = 0;
   int   cur_lat = 0;

   // Reference model state
   exp_t        sb[$];
   int          m_left    = 0;
   logic        m_multi   = 1'b0;
   logic [23:0] m_onehot  = '0;
   logic [22:0] m_fields  = '0;
   logic        m_overrun = 1'b0;
   int unsigned m_perf_iss  = 0;
   int unsigned m_perf_busy = 0;

   fpu_decode_issue_if bus ();

   fpu_decode_issue #(
      .DIV_LAT  (DIV_LAT),
      .SQRT_LAT (SQRT_LAT),
      .FMA_LAT  (FMA_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rs3, input logic [2:0] rm);
      return {4'h0, rm, rs3, rs2, rs1, rd, op};
   endfunction

   // Drive one instruction word for one cycle, advance the model, check outputs
   task automatic step(input logic [31:0] x, input logic r);
      logic       prev_busy;
      logic       e_issue;
      logic       e_halt;
      logic       e_ill;
      logic [4:0] opc;
      exp_t       e;
      exp_t       got;
      bus.instr_in = x;
      rst          = r;
      opc          = x[4:0];
      e_issue      = 1'b0;
      e_halt       = 1'b0;
      e_ill        = 1'b0;
      @(posedge clk);
      prev_busy = (m_left > 0);
      if (r) begin
         m_left    = 0;
         m_multi   = 1'b0;
         m_onehot  = '0;
         m_fields  = '0;
         m_overrun = 1'b0;
         m_perf_iss  = 0;
         m_perf_busy = 0;
         sb.delete();
      end else begin
         if (m_left > 0) m_left--;
         if (x != 32'd0) begin
            if (prev_busy) begin
               m_overrun = 1'b1;
            end else if (x == HALT_W) begin
               e_halt = 1'b1;
            end else if (opc > 5'd23) begin
               e_ill = 1'b1;
            end else begin
               e_issue  = 1'b1;
               e.onehot = 24'd1 << opc;
               e.fields = x[27:5];
               e.multi  = (opc inside {5'd3, 5'd4, 5'd12, 5'd13, 5'd16, 5'd17});
               e.lat    = !e.multi ? 0 : (opc == 5'd3) ? DIV_LAT :
                          (opc == 5'd4) ? SQRT_LAT : FMA_LAT;
               sb.push_back(e);
               m_left   = e.multi ? e.lat + 1 : 1;
               m_multi  = e.multi;
               m_onehot = e.onehot;
               m_fields = e.fields;
            end
         end
      end
      @(negedge clk);
      cyc++;
      chk("issue_valid", 32'(bus.issue_valid), 32'(e_issue));
      chk("busy", 32'(bus.busy), 32'(m_left > 0));
      chk("multi_cycle", 32'(bus.multi_cycle), 32'((m_left > 0) && m_multi));
      chk("activation", 32'(bus.activation_signal), 32'((m_left == 1) || e_ill));
      chk("illegal_op", 32'(bus.illegal_op), 32'(e_ill));
      chk("halt", 32'(bus.halt), 32'(e_halt));
      chk("overrun", 32'(bus.overrun), 32'(m_overrun));
      chk("op_onehot", 32'(bus.op_onehot), 32'((m_left > 0) ? m_onehot : 24'd0));
      chk("fields", 32'({bus.rm, bus.rs3, bus.rs2, bus.rs1, bus.rd}), 32'(m_fields));
      if (bus.issue_valid) begin
         chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("sb_onehot", 32'(bus.op_onehot), 32'(got.onehot));
            chk("sb_fields", 32'({bus.rm, bus.rs3, bus.rs2, bus.rs1, bus.rd}), 32'(got.fields));
            chk("sb_multi", 32'(bus.multi_cycle), 32'(got.multi));
            t_issue = cyc;
            cur_lat = got.lat;
         end
      end
      if (bus.activation_signal && !bus.issue_valid && !bus.illegal_op) begin
         chk("done_latency", 32'(cyc - t_issue), 32'(cur_lat));
      end
`ifdef FPU_DECODE_PERF_CNT_EN
      chk("perf_issued", bus.perf_issued, m_perf_iss);
      chk("perf_busy_cycles", bus.perf_busy_cycles, m_perf_busy);
      if (!r) begin
         m_perf_iss  += 32'(e_issue);
         m_perf_busy += 32'(m_left > 0);
      end
`endif
   endtask

   initial begin
      bus.instr_in = '0;
      rst          = 1'b1;

      // Reset, then idle bubbles
      step(32'd0, 1'b1);
      step(32'd0, 1'b1);
      repeat (10) step(32'd0, 1'b0);

      // Single-cycle fadd with mixed fields
      step(32'h0A2C_8840, 1'b0);
      step(32'd0, 1'b0);

      // fdiv through to completion
      step(mk(5'd3, 5'd7, 5'd1, 5'd2, 5'd0, 3'd1), 1'b0);
      repeat (14) step(32'd0, 1'b0);

      // fmadd, then fmul accepted in the first idle cycle after DONE
      step(mk(5'd12, 5'd31, 5'd30, 5'd29, 5'd28, 3'd7), 1'b0);
      repeat (4) step(32'd0, 1'b0);
      step(mk(5'd2, 5'd4, 5'd5, 5'd6, 5'd0, 3'd0), 1'b0);
      step(32'd0, 1'b0);

      // fadd / fsub back to back around a single-cycle EXEC
      step(mk(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 3'd2), 1'b0);
      step(32'd0, 1'b0);
      step(mk(5'd1, 5'd9, 5'd10, 5'd11, 5'd0, 3'd3), 1'b0);
      step(32'd0, 1'b0);

      // Halt word, illegal opcodes 25 and 31, opcode 16 with non-zero fields
      step(HALT_W, 1'b0);
      step(32'd0, 1'b0);
      step(mk(5'd25, 5'd3, 5'd3, 5'd3, 5'd3, 3'd3), 1'b0);
      step(mk(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 3'd0), 1'b0);
      step(32'd0, 1'b0);
      step(32'h0000_0030, 1'b0);
      repeat (4) step(32'd0, 1'b0);

      // fmadd presented three cycles into an fdiv: ignored, overrun sticks
      step(mk(5'd3, 5'd12, 5'd13, 5'd14, 5'd0, 3'd4), 1'b0);
      step(32'd0, 1'b0);
      step(32'd0, 1'b0);
      step(mk(5'd12, 5'd1, 5'd1, 5'd1, 5'd1, 3'd1), 1'b0);
      repeat (12) step(32'd0, 1'b0);

      // Reset during fsqrt WAIT aborts it; a following fadd issues normally
      step(mk(5'd4, 5'd20, 5'd21, 5'd0, 5'd0, 3'd6), 1'b0);
      repeat (3) step(32'd0, 1'b0);
      step(32'd0, 1'b1);
      step(mk(5'd0, 5'd8, 5'd16, 5'd24, 5'd1, 3'd5), 1'b0);
      step(32'd0, 1'b0);

      // fmsubb with fnmadd landing while busy, then drain
      step(mk(5'd13, 5'd2, 5'd4, 5'd8, 5'd16, 3'd2), 1'b0);
      step(mk(5'd17, 5'd3, 5'd3, 5'd3, 5'd3, 3'd3), 1'b0);
      repeat (4) step(32'd0, 1'b0);

      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
